// File: rtl/fetch_stage.sv
// fetch_stage: holds the PC, issues one imem read at a time, presents insn/pc to decode via an IF/ID register.
// Latency: 2 edges from request to insn_valid with 1-cycle memory; one instruction every 2 cycles unstalled.
// Backpressure: id_stall holds the output register and parks one response; FETCH_ALIGN_CHECK_EN enables misaligned-redirect fault.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h8002_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        id_stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] insn_out,
    output logic [31:0] pc_out,
    output logic        insn_valid,
    output logic        fetch_fault
);
    typedef enum logic [1:0] {ISSUE, WAIT, HOLD} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] pend_insn, pend_pc;
    logic        discard, discard_nxt;
    logic        take_rsp, park, unpark;
    logic        halt;
    logic [31:0] redirect_tgt;

`ifdef FETCH_ALIGN_CHECK_EN
    logic fault_q;

    assign redirect_tgt = redirect_pc;
    assign halt         = fault_q;
    assign fetch_fault  = fault_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            fault_q <= 1'b0;
        else if (redirect_valid && (redirect_pc[1:0] != 2'b00))
            fault_q <= 1'b1;
    end
`else
    logic unused_lsbs;

    assign unused_lsbs  = ^redirect_pc[1:0];
    assign redirect_tgt = {redirect_pc[31:2], 2'b00};
    assign halt         = 1'b0;
    assign fetch_fault  = 1'b0;
`endif

    assign imem_addr = pc;

    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        discard_nxt = discard;
        take_rsp    = 1'b0;
        park        = 1'b0;
        unpark      = 1'b0;
        // A redirect in the issue cycle suppresses the request, so no stale response is ever launched from ISSUE.
        imem_req    = (state == ISSUE) && !reset && !redirect_valid && !halt;

        case (state)
            ISSUE: begin
                if (imem_req)
                    state_nxt = WAIT;
            end
            WAIT: begin
                if (imem_rvalid) begin
                    if (discard) begin
                        discard_nxt = 1'b0;
                        state_nxt   = ISSUE;
                    end else if (!insn_valid || !id_stall) begin
                        take_rsp  = 1'b1;
                        pc_nxt    = pc + 32'd4;
                        state_nxt = ISSUE;
                    end else begin
                        park      = 1'b1;
                        pc_nxt    = pc + 32'd4;
                        state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                if (!id_stall) begin
                    unpark    = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            default: state_nxt = ISSUE;
        endcase

        if (redirect_valid) begin
            take_rsp = 1'b0;
            park     = 1'b0;
            unpark   = 1'b0;
            pc_nxt   = redirect_tgt;
            if (state == WAIT && !imem_rvalid) begin
                discard_nxt = 1'b1;
                state_nxt   = WAIT;
            end else begin
                discard_nxt = 1'b0;
                state_nxt   = ISSUE;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= ISSUE;
            pc      <= RESET_PC;
            discard <= 1'b0;
        end else begin
            state   <= state_nxt;
            pc      <= pc_nxt;
            discard <= discard_nxt;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            insn_out   <= 32'h0;
            pc_out     <= 32'h0;
            insn_valid <= 1'b0;
            pend_insn  <= 32'h0;
            pend_pc    <= 32'h0;
        end else begin
            if (take_rsp) begin
                insn_out   <= imem_rdata;
                pc_out     <= pc;
                insn_valid <= 1'b1;
            end else if (unpark) begin
                insn_out   <= pend_insn;
                pc_out     <= pend_pc;
                insn_valid <= 1'b1;
            end else if (redirect_valid || !id_stall) begin
                insn_valid <= 1'b0;
            end

            if (redirect_valid) begin
                pend_insn <= 32'h0;
                pend_pc   <= 32'h0;
            end else if (park) begin
                pend_insn <= imem_rdata;
                pend_pc   <= pc;
            end
        end
    end
endmodule
